// File: rtl/quant_pkg.sv
// quant_pkg: shared constants, row tag payload and the round/saturate helper
// for the JPEG quantizer datapath.
package quant_pkg;

    // Rows per 8x8 block and width of the in-block row index.
    localparam int unsigned BLK_ROWS = 8;
    localparam int unsigned ROW_W    = 3;

    // Table entry index is row*8 + lane.
    localparam int unsigned TBL_AW   = 6;

    // Working width for rounding; wide enough for any sane product width.
    localparam int unsigned CALC_W   = 64;

    // Control tag that travels alongside each row through the pipeline.
    typedef struct packed {
        logic valid;
        logic sop;
        logic eob;
    } row_tag_t;

    // Round half toward +inf after an arithmetic right shift by sh, then
    // clamp to the signed range of an out_w-bit result.
    function automatic logic signed [CALC_W-1:0] round_sat(
        input logic signed [CALC_W-1:0] p,
        input int unsigned              sh,
        input int unsigned              out_w
    );
        logic signed [CALC_W-1:0] half;
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        half = 64'sd1 <<< (sh - 1);
        r    = (p + half) >>> sh;
        hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/quant_lane.sv
// quant_lane: one coefficient lane of the quantizer.
//   S1 register: signed coef times unsigned reciprocal (plus DC flag).
//   S2 register: round + saturate into the lane's output field.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_s1         capture a new product (row accepted)
//   load_out        move S1 into the output register
//   coef            signed input coefficient
//   recip           unsigned reciprocal from the active table
//   dc              lane carries the block's DC term (row 0, lane 0)
//   q               saturated quantized coefficient
module quant_lane
    import quant_pkg::*;
#(
    parameter int unsigned IN_W    = 12,
    parameter int unsigned RECIP_W = 8,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned FRAC    = 11,
    parameter int unsigned DC_FRAC = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_s1,
    input  logic               load_out,
    input  logic [IN_W-1:0]    coef,
    input  logic [RECIP_W-1:0] recip,
    input  logic               dc,
    output logic [OUT_W-1:0]   q
);

    localparam int unsigned PW = IN_W + RECIP_W + 1;

    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] s1_prod;
    logic                 s1_dc;

    // Reciprocal is zero-extended so the product stays signed.
    always_comb begin
        prod_c = PW'($signed(coef)) * PW'($signed({1'b0, recip}));
    end

    // Product stage and round/saturate stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_prod <= '0;
            s1_dc   <= 1'b0;
            q       <= '0;
        end else begin
            if (load_s1) begin
                s1_prod <= prod_c;
                s1_dc   <= dc;
            end
            if (load_out) begin
                q <= OUT_W'(round_sat(CALC_W'(s1_prod), s1_dc ? DC_FRAC : FRAC, OUT_W));
            end
        end
    end

endmodule

// File: rtl/quant_pipe.sv
// quant_pipe: pipelined JPEG quantizer, one row of LANES coefficients per beat.
// Tracks the row index within each 8x8 block, looks up per-entry reciprocals
// from one of NUM_TBL runtime-writable tables, multiplies, rounds, saturates.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data       input row handshake (lane 0 in MSBs)
//   in_sop, in_tbl                  row 0 marker and table select for the block
//   out_valid/out_ready/out_data    output row handshake (lane 0 in MSBs)
//   out_sop, out_eob                output row is row 0 / row 7
//   tbl_we/tbl_sel/tbl_addr/tbl_wdata  reciprocal table write port
//   err_sync, err_clr               sticky mid-block sop flag and its clear
module quant_pipe
    import quant_pkg::*;
#(
    parameter int unsigned LANES   = 8,
    parameter int unsigned IN_W    = 12,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned RECIP_W = 8,
    parameter int unsigned FRAC    = 11,
    parameter int unsigned DC_FRAC = 9,
    parameter int unsigned NUM_TBL = 2,
    localparam int unsigned TBL_W  = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_sop,
    input  logic [TBL_W-1:0]       in_tbl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_sop,
    output logic                   out_eob,
    input  logic                   tbl_we,
    input  logic [TBL_W-1:0]       tbl_sel,
    input  logic [TBL_AW-1:0]      tbl_addr,
    input  logic [RECIP_W-1:0]     tbl_wdata,
    output logic                   err_sync,
    input  logic                   err_clr
);

    localparam int unsigned TBL_DEPTH = 2 ** TBL_AW;

    logic [RECIP_W-1:0] tbl_mem [NUM_TBL][TBL_DEPTH];

    logic [ROW_W-1:0] row_cnt;
    logic [TBL_W-1:0] tbl_act;
    row_tag_t         s1_tag;
    row_tag_t         out_tag;

    logic             advance_c;
    logic             accept_c;
    logic             err_set_c;
    logic [ROW_W-1:0] row_use_c;
    logic [TBL_W-1:0] tbl_use_c;

    // Whole pipeline moves together; it only stalls when the output is held.
    always_comb begin
        advance_c = !out_valid || out_ready;
        accept_c  = in_valid && advance_c;
        // An sop row restarts the block and selects its table immediately.
        row_use_c = in_sop ? '0 : row_cnt;
        tbl_use_c = in_sop ? in_tbl : tbl_act;
        err_set_c = accept_c && in_sop && (row_cnt != '0);
    end

    assign in_ready  = advance_c;
    assign out_valid = out_tag.valid;
    assign out_sop   = out_tag.sop;
    assign out_eob   = out_tag.eob;

    // Row counter, active table, pipeline tags and sticky sync error.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt  <= '0;
            tbl_act  <= '0;
            s1_tag   <= '0;
            out_tag  <= '0;
            err_sync <= 1'b0;
        end else begin
            if (accept_c) begin
                // BLK_ROWS is a power of two, so 7 -> 0 wraps naturally.
                row_cnt <= row_use_c + ROW_W'(1);
                if (in_sop) begin
                    tbl_act <= in_tbl;
                end
            end
            if (advance_c) begin
                s1_tag  <= '{valid: accept_c,
                             sop:   (row_use_c == '0),
                             eob:   (row_use_c == ROW_W'(BLK_ROWS - 1))};
                out_tag <= s1_tag;
            end
            // A new error wins over a simultaneous clear.
            if (err_set_c) begin
                err_sync <= 1'b1;
            end else if (err_clr) begin
                err_sync <= 1'b0;
            end
        end
    end

    // Reciprocal tables; a read in the write cycle returns the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < int'(NUM_TBL); t++) begin
                for (int e = 0; e < int'(TBL_DEPTH); e++) begin
                    tbl_mem[t][e] <= '0;
                end
            end
        end else if (tbl_we) begin
            tbl_mem[tbl_sel][tbl_addr] <= tbl_wdata;
        end
    end

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        logic [TBL_AW-1:0]  addr_c;
        logic [RECIP_W-1:0] recip_c;

        always_comb begin
            addr_c  = TBL_AW'(32'(row_use_c) * LANES + 32'(l));
            recip_c = tbl_mem[tbl_use_c][addr_c];
        end

        quant_lane #(
            .IN_W    (IN_W),
            .RECIP_W (RECIP_W),
            .OUT_W   (OUT_W),
            .FRAC    (FRAC),
            .DC_FRAC (DC_FRAC)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load_s1  (accept_c),
            .load_out (advance_c && s1_tag.valid),
            .coef     (in_data[(LANES-1-l)*IN_W +: IN_W]),
            .recip    (recip_c),
            .dc       ((row_use_c == '0) && (l == 0)),
            .q        (out_data[(LANES-1-l)*OUT_W +: OUT_W])
        );
    end

endmodule
